// File: rtl/miriscv_dmem_pkg.sv
// -----------------------------------------------------------------------------
// miriscv_dmem_pkg
//
// Shared definitions for the data-memory responder slice:
//   XLEN          - data/address width of the core's data interface
//   DMEM_LAT_W    - width of the response latency down-counter (LATENCY <= 15)
//   dmem_state_e  - responder FSM states
//   dmem_in_range - range check on an address already rebased to BASE_ADDR
// -----------------------------------------------------------------------------
package miriscv_dmem_pkg;

  localparam int XLEN       = 32;
  localparam int DMEM_LAT_W = 4;

  // IDLE: ready to accept a request.
  // WAIT: request accepted, counting down the remaining latency.
  // RESP: last cycle before the response pulse; the request lines still belong
  //       to the transaction being finished and are ignored.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // True when a rebased byte offset falls inside the array. The compare is
  // done one bit wider than XLEN so that MEM_WORDS*4 cannot wrap to zero.
  function automatic logic dmem_in_range(input logic [XLEN-1:0] offset,
                                         input int unsigned     mem_words);
    return {1'b0, offset} < ({1'b0, XLEN'(mem_words)} << 2);
  endfunction

endpackage : miriscv_dmem_pkg

// File: rtl/miriscv_dmem_array.sv
// -----------------------------------------------------------------------------
// miriscv_dmem_array
//
// Synchronous single-port word RAM with byte-lane write masking.
//
// Ports:
//   clk_i    in  1          rising-edge clock
//   en_i     in  1          access enable; no read or write without it
//   we_i     in  1          1 = write the enabled lanes, 0 = read only
//   be_i     in  XLEN/8     byte-lane write enables (ignored when we_i = 0)
//   addr_i   in  log2(WORDS) word index
//   wdata_i  in  XLEN       write data
//   rdata_o  out XLEN       registered read data; updated only on enabled
//                           cycles and returns the word as it was before any
//                           write in that same cycle (read-first)
// -----------------------------------------------------------------------------
module miriscv_dmem_array
  import miriscv_dmem_pkg::*;
#(
  parameter int unsigned WORDS = 1024
) (
  input  logic                      clk_i,
  input  logic                      en_i,
  input  logic                      we_i,
  input  logic [XLEN/8-1:0]         be_i,
  input  logic [$clog2(WORDS)-1:0]  addr_i,
  input  logic [XLEN-1:0]           wdata_i,
  output logic [XLEN-1:0]           rdata_o
);

  logic [XLEN-1:0] mem [WORDS];

  // NOTE: the storage and its read register deliberately have no reset: a RAM
  // macro cannot be cleared in one cycle, and the responder only ever forwards
  // rdata_o after an enabled read has loaded it.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int lane = 0; lane < XLEN/8; lane++) begin
          if (be_i[lane]) begin
            mem[addr_i][8*lane +: 8] <= wdata_i[8*lane +: 8];
          end
        end
      end
      rdata_o <= mem[addr_i];
    end
  end

endmodule : miriscv_dmem_array

// File: rtl/miriscv_dmem_responder.sv
// -----------------------------------------------------------------------------
// miriscv_dmem_responder
//
// Memory-side responder for the core's data interface. Accepts one load or
// store at a time, performs it on a local word array at the acceptance edge,
// and answers with a one-cycle data_rvalid_o pulse LATENCY cycles later.
// Back-to-back requests are served once every LATENCY+1 cycles.
//
// Parameters:
//   MEM_WORDS  array depth in 32-bit words (power of two, >= 2)
//   LATENCY    cycles from acceptance edge to the response pulse (1..15)
//   BASE_ADDR  byte address of word 0, aligned to MEM_WORDS*4
//
// Ports:
//   clk_i         in  1       rising-edge clock
//   arstn_i       in  1       asynchronous active-low reset
//   data_req_i    in  1       request from the core
//   data_we_i     in  1       1 = store, 0 = load
//   data_be_i     in  XLEN/8  byte enables (stores only)
//   data_addr_i   in  XLEN    byte address; bits [1:0] are ignored
//   data_wdata_i  in  XLEN    store data
//   data_rvalid_o out 1       one-cycle response pulse (loads and stores)
//   data_rdata_o  out XLEN    load data; 0 for stores and out-of-range loads
//   data_err_o    out 1       out-of-range flag, qualified by data_rvalid_o
// -----------------------------------------------------------------------------
module miriscv_dmem_responder
  import miriscv_dmem_pkg::*;
#(
  parameter int unsigned     MEM_WORDS = 1024,
  parameter int unsigned     LATENCY   = 1,
  parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [XLEN/8-1:0] data_be_i,
  input  logic [XLEN-1:0]   data_addr_i,
  input  logic [XLEN-1:0]   data_wdata_i,
  output logic              data_rvalid_o,
  output logic [XLEN-1:0]   data_rdata_o,
  output logic              data_err_o
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  dmem_state_e           state_q;
  logic [DMEM_LAT_W-1:0] cnt_q;
  logic                  we_q;
  logic                  err_q;

  logic [XLEN-1:0]       offset;
  logic [IDX_W-1:0]      word_idx;
  logic                  in_range;
  logic                  accept;
  logic [XLEN-1:0]       arr_rdata;

  // Rebase the address once; both the word index and the range check use it.
  // The unsigned subtraction makes addresses below BASE_ADDR wrap to huge
  // offsets, so they fall out of range without a separate lower-bound test.
  assign offset   = data_addr_i - BASE_ADDR;
  assign word_idx = offset[IDX_W+1:2];
  assign in_range = dmem_in_range(offset, MEM_WORDS);
  assign accept   = (state_q == IDLE) && data_req_i;

  // The array is touched only at the acceptance edge. Gating the enable with
  // in_range suppresses out-of-range stores; for a load, the array's read
  // register doubles as the response data holding register, since nothing
  // re-enables the array until the transaction has completed. This is also
  // why be and the word index need no separate latch here.
  miriscv_dmem_array #(
    .WORDS   (MEM_WORDS)
  ) u_array (
    .clk_i   (clk_i),
    .en_i    (accept && in_range),
    .we_i    (data_we_i),
    .be_i    (data_be_i),
    .addr_i  (word_idx),
    .wdata_i (data_wdata_i),
    .rdata_o (arr_rdata)
  );

  // FSM, latency counter, request latch and registered response outputs.
  // The response registers are loaded on the RESP -> IDLE edge, so the pulse
  // appears in the first IDLE cycle and a request still held there is taken
  // as a new transaction at the following edge.
  // NOTE: every register in this block uses non-blocking assignment so that
  // all of them update from the same pre-edge values, matching the hardware.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      err_q         <= 1'b0;
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= '0;
      data_err_o    <= 1'b0;
    end else begin
      // Response outputs are single-cycle unless RESP re-asserts them below.
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= '0;
      data_err_o    <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (data_req_i) begin
            we_q  <= data_we_i;
            err_q <= !in_range;
            if (LATENCY == 1) begin
              state_q <= RESP;
            end else begin
              // Acceptance and RESP each account for one cycle of latency.
              state_q <= WAIT;
              cnt_q   <= DMEM_LAT_W'(int'(LATENCY) - 2);
            end
          end
        end

        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - DMEM_LAT_W'(1);
          end
        end

        RESP: begin
          data_rvalid_o <= 1'b1;
          data_err_o    <= err_q;
          data_rdata_o  <= (we_q || err_q) ? '0 : arr_rdata;
          state_q       <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule : miriscv_dmem_responder

// File: doc/miriscv_dmem_responder.md
# miriscv_dmem_responder

Memory-side responder for the core's data memory interface (req/we/be/addr/wdata out of the LSU, rvalid/rdata back). It accepts one load or store at a time, applies byte-enabled writes to a local word array, and returns a single-cycle `data_rvalid_o` pulse after a fixed, parameterised latency. It is used as tightly coupled data RAM in the SoC and as the reference memory in core-level benches.

## Interface
- `MEM_WORDS`, 1024: array depth in 32-bit words, power of two, ≥ 2.
- `LATENCY`, 1: cycles from acceptance to `data_rvalid_o`, range 1–15.
- `BASE_ADDR`, 32'h0: byte address of word 0, aligned to `MEM_WORDS*4`.
- `clk_i` in 1: single clock; all logic is on the rising edge.
- `arstn_i` in 1: asynchronous, active-low reset.
- `data_req_o`-side inputs, driven by the core:
  - `data_req_i` in 1: request.
  - `data_we_i` in 1: 1 = store, 0 = load.
  - `data_be_i` in XLEN/8: byte lane enables.
  - `data_addr_i` in XLEN: byte address.
  - `data_wdata_i` in XLEN: store data.
- `data_rvalid_o` out 1: one-cycle response pulse, for loads and stores.
- `data_rdata_o` out XLEN: load data, valid only when `data_rvalid_o` = 1.
- `data_err_o` out 1: out-of-range access flag, qualified by `data_rvalid_o`.

## Operation
- States are IDLE, WAIT, and RESP.
- Acceptance:
  - In IDLE with `data_req_i` = 1, the request is accepted.
  - `we`, `be`, the word index, and the range check are latched at acceptance.
  - Later changes on the inputs are ignored until the transaction completes.
- Word index is `(data_addr_i - BASE_ADDR) >> 2`. `addr[1:0]` is ignored.
- Out-of-range: `data_addr_i - BASE_ADDR ≥ MEM_WORDS*4`, unsigned.
- Store:
  - At the acceptance edge, each lane `i` with `be[i]` = 1 writes `wdata[8i+7:8i]`.
  - If every `be` bit is 0, nothing is written.
  - `data_rdata_o` = 0 during the response.
- Load:
  - The full word is read at the acceptance edge.
  - `be` is ignored.
  - The word is held in a response register until RESP.
- Out-of-range store: no write. Out-of-range load: returns 0. Both set `data_err_o` = 1 for the response cycle.
- Transitions:
  - IDLE→RESP when `LATENCY` = 1.
  - IDLE→WAIT when `LATENCY` > 1; the down-counter is loaded with `LATENCY-2`.
  - WAIT→RESP when the counter reaches 0.
  - RESP→IDLE always. `data_req_i` is ignored in RESP.
- Handshake contract:
  - The core holds `data_req_i` and its fields stable until the `data_rvalid_o` cycle.
  - In the RESP cycle, `data_req_i` still belongs to the finished transaction.
  - A request seen in the cycle after RESP is a new transaction.
- Store-then-load to the same word: the load returns the stored value, because the write completes at the store's acceptance edge.
- `data_rvalid_o`, `data_rdata_o`, and `data_err_o` are registered. No input-to-output combinational path.

## Timing
- Reset values:
  - State is IDLE and the counter is 0.
  - `data_rvalid_o` = 0, `data_rdata_o` = 0, `data_err_o` = 0.
  - Array contents are not reset.
- Latency: request accepted at edge N gives `data_rvalid_o` high during cycle N+`LATENCY`, for exactly one cycle.
- Throughput: one transaction per `LATENCY`+1 cycles with back-to-back requests.
- Reset asserted mid-transaction:
  - The pending response is dropped and no `data_rvalid_o` is issued.
  - A store already accepted stays written.
- `data_req_i` = 0 in IDLE: the block stays idle and all outputs hold 0.

## Structure
- Shared package `miriscv_dmem_pkg`:
  - `dmem_state_e` (IDLE, WAIT, RESP).
  - `DMEM_LAT_W` = 4.
  - Range-check helper function.
- Sub-module `miriscv_dmem_array`: synchronous byte-enabled single-port RAM.
  - Ports: `clk_i`, `en_i`, `we_i`, `be_i`, `addr_i`, `wdata_i`, `rdata_o`.
  - Read data registered; write is byte-masked.
- Top level: FSM, latency counter, request latch, range check, response registers.

## Test plan
- Store/load, `LATENCY` = 1:
  - Store `0xDEADBEEF` to `0x10`, `be` = 4'hF → `rvalid` 1 cycle after acceptance, `rdata` 0, `err` 0.
  - Next load from `0x10` → `rdata` = `0xDEADBEEF`.
- Byte enables: word = `0x11223344`; store `0xAABBCCDD`, `be` = 4'b0101 → subsequent load returns `0x11BB33DD`.
- Latency and hold, `LATENCY` = 3: request held from cycle 0 → `rvalid` only in cycle 3; no second `rvalid` in cycle 4; held request accepted again in cycle 4.
- Out of range, `MEM_WORDS` = 1024:
  - Load from `0x1000` → `rvalid` with `err` = 1, `rdata` = 0.
  - Store to `0x1000` → `err` = 1; word 0 unchanged.
- Reset mid-flight, `LATENCY` = 4: `arstn_i` low at cycle 2 → outputs 0 immediately, no `rvalid`; after release, a load from the stored address still returns the stored data.
